// File: rtl/add_pkg.sv
// Shared constants for the nibble-serial adder: nibble width and FSM state encoding.
// Also provides the index-width helper so the top and any reuse agree on it.
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder, purely combinational.
// Zero latency; no flow control.
module nibble_serial_adder_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin
    logic c;
    c   = ci;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams one nibble per cycle through a 4-bit RCA; result valid NIBBLES edges after accept.
// Backpressure: result held in DONE while out_ready is low; no new operands accepted until it drains.
module nibble_serial_adder
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      ci,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);

  state_t          state, state_nxt;
  logic [W-1:0]    a_sh, b_sh, sum_nxt;
  logic            carry, a_msb, b_msb;
  logic [IW-1:0]   idx;
  logic [3:0]      rca_sum;
  logic            rca_cout;
  logic            last;

  nibble_serial_adder_rca u_rca (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .ci   (carry),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    sum_nxt                      = sum >> NIBBLE_W;
    sum_nxt[W-1 -: NIBBLE_W]     = rca_sum;
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            a_msb <= a[W-1];
            b_msb <= b[W-1];
            idx   <= '0;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          sum   <= sum_nxt;
          carry <= rca_cout;
          // idx saturates at the last nibble instead of wrapping
          if (last) begin
            cout <= rca_cout;
            ovf  <= (a_msb == b_msb) && (sum_nxt[W-1] != a_msb);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, ci, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid1, in_ready1, ci1, out_valid1, out_ready1, cout1, ovf1;
  logic [3:0]  a1, b1, sum1;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .ci(ci1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 30);
  endtask

  task automatic drain4(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 1'b0);
    check({tag, "_ir_back"}, in_ready, 1'b1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tci, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb; ci = tci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid4(n);
    check({tag, "_lat"},  n, 4);
    check({tag, "_sum"},  sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"},  ovf, eo);
    drain4(tag);
  endtask

  initial begin
    int n;
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, got, exp_ovf;
    logic [17:0] obs_r;

    rst_n = 1'b0;
    in_valid = 0; a = '0; b = '0; ci = 0; out_ready = 0;
    in_valid1 = 0; a1 = '0; b1 = '0; ci1 = 0; out_ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum",       sum, 16'h0);
    check("rst_cout",      cout, 1'b0);
    check("rst_ovf",       ovf, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("t1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("t2a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("t2b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // operands injected mid-RUN and during DONE must be ignored
    a = 16'h1234; b = 16'h4321; ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'hAAAA; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid4(n);
    check("t3_ov",   out_valid, 1'b1);
    check("t3_sum",  sum, 16'h5556);
    check("t3_cout", cout, 1'b0);
    check("t3_ovf",  ovf, 1'b0);
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t3_hold_ov",  out_valid, 1'b1);
    check("t3_hold_sum", sum, 16'h5556);
    check("t3_hold_ir",  in_ready, 1'b0);
    drain4("t3");
    check("t3_sum_kept", sum, 16'h5556);

    // async reset in the middle of RUN
    a = 16'h1111; b = 16'h2222; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_ov",  out_valid, 1'b0);
    check("t5_ir",  in_ready, 1'b1);
    check("t5_sum", sum, 16'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("t5n", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // single-nibble instance
    a1 = 4'hF; b1 = 4'h1; ci1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid1 && n < 30);
    check("t6_lat",  n, 1);
    check("t6_sum",  sum1, 4'h1);
    check("t6_cout", cout1, 1'b1);
    check("t6_ovf",  ovf1, 1'b0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("t6_ov_drop", out_valid1, 1'b0);

    // randomized scoreboard with random consumer stalls
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      full    = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      exp_ovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      a = ra; b = rb; ci = rc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0;
      obs_r = '0;
      for (int c = 0; c < 200 && !got; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (out_valid && out_ready) begin
          obs_r = {cout, ovf, sum};
          got = 1'b1;
        end
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check($sformatf("rnd%0d", k), obs_r, {full[16], exp_ovf, full[15:0]});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
